// File: rtl/cache_axi_bridge_pkg.sv
// rtl/cache_axi_bridge_pkg.sv - shared state encoding, AXI constants and reset level for cache_axi_bridge
`ifndef RST_ENABLE
`define RST_ENABLE 1'b1
`endif

package cache_axi_bridge_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_AWW,
    S_B,
    S_RESP
  } bridge_state_e;

  localparam logic [7:0] LEN_SINGLE   = 8'd0;
  localparam logic [2:0] SIZE_WORD    = 3'b010;
  localparam logic [1:0] BURST_INCR   = 2'b01;
  localparam logic [1:0] LOCK_NORMAL  = 2'b00;
  localparam logic [2:0] PROT_DEFAULT = 3'b000;
  localparam logic [3:0] CACHE_WB     = 4'b1111;
  localparam logic [3:0] CACHE_UC     = 4'b0000;

  function automatic logic [3:0] axi_cache(input logic cacheable);
    return cacheable ? CACHE_WB : CACHE_UC;
  endfunction
endpackage

// File: rtl/cache_axi_bridge_if.sv
// rtl/cache_axi_bridge_if.sv - AXI3 channel bundle between the bridge (master) and the memory slave
interface cache_axi_bridge_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/cache_axi_bridge.sv
// rtl/cache_axi_bridge.sv - single-outstanding AXI3 master behind the CPU SRAM-style inst/data ports
// Optional BRIDGE_EARLY_WACK_EN: ack writes once AW/W are done and drain B in the background.
module cache_axi_bridge
  import cache_axi_bridge_pkg::*;
#(
  parameter logic [3:0] INST_ID = 4'd0,
  parameter logic [3:0] DATA_ID = 4'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst_addr_i,
  input  logic        inst_ren_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_rd_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_ren_i,
  input  logic [3:0]  data_wen_i,
  input  logic [31:0] data_wd_i,
  output logic        data_valid_o,
  output logic [31:0] data_rd_o,
  input  logic        is_cache_i,
  cache_axi_bridge_if.master axi
);

  bridge_state_e state_q;
  logic [31:0] addr_q, wd_q, inst_rd_q, data_rd_q;
  logic [3:0]  wen_q;
  logic        cache_q, src_data_q;
  logic        arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
  logic        aw_done_q, w_done_q, inst_valid_q, data_valid_q;
  logic        aw_done_d, w_done_d, accept_ok;
  logic        unused_axi;

  assign aw_done_d = aw_done_q | (awvalid_q & axi.awready);
  assign w_done_d  = w_done_q  | (wvalid_q & axi.wready);

`ifdef BRIDGE_EARLY_WACK_EN
  // bready_q stays high while an early-acked write still owes its B beat
  assign accept_ok = ~bready_q;
`else
  assign accept_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst == `RST_ENABLE) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wd_q         <= '0;
      wen_q        <= '0;
      cache_q      <= 1'b0;
      src_data_q   <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      aw_done_q    <= 1'b0;
      w_done_q     <= 1'b0;
      inst_valid_q <= 1'b0;
      data_valid_q <= 1'b0;
      inst_rd_q    <= '0;
      data_rd_q    <= '0;
    end else begin
      inst_valid_q <= 1'b0;
      data_valid_q <= 1'b0;
      if (bready_q && axi.bvalid) begin
        bready_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (accept_ok && (data_ren_i || (data_wen_i != 4'b0000) || inst_ren_i)) begin
            wd_q       <= data_wd_i;
            wen_q      <= data_wen_i;
            cache_q    <= is_cache_i;
            src_data_q <= data_ren_i || (data_wen_i != 4'b0000);
            addr_q     <= (data_ren_i || (data_wen_i != 4'b0000)) ? data_addr_i : inst_addr_i;
            if (!data_ren_i && (data_wen_i != 4'b0000)) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              aw_done_q <= 1'b0;
              w_done_q  <= 1'b0;
              state_q   <= S_AWW;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= S_AR;
            end
          end
        end
        S_AR: begin
          if (axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= S_R;
          end
        end
        S_R: begin
          if (axi.rvalid) begin
            rready_q <= 1'b0;
            if (src_data_q) begin
              data_rd_q    <= axi.rdata;
              data_valid_q <= 1'b1;
            end else begin
              inst_rd_q    <= axi.rdata;
              inst_valid_q <= 1'b1;
            end
            state_q <= S_RESP;
          end
        end
        S_AWW: begin
          aw_done_q <= aw_done_d;
          w_done_q  <= w_done_d;
          if (axi.awready) awvalid_q <= 1'b0;
          if (axi.wready)  wvalid_q  <= 1'b0;
          if (aw_done_d && w_done_d) begin
            bready_q <= 1'b1;
`ifdef BRIDGE_EARLY_WACK_EN
            data_valid_q <= 1'b1;
            state_q      <= S_RESP;
`else
            state_q      <= S_B;
`endif
          end
        end
        S_B: begin
          if (axi.bvalid) begin
            data_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end
        end
        S_RESP:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Response id/resp/last are deliberately not checked: one transaction in flight, single beat.
  assign unused_axi = ^{axi.rid, axi.rresp, axi.rlast, axi.bid, axi.bresp};

  assign axi.arid    = src_data_q ? DATA_ID : INST_ID;
  assign axi.araddr  = addr_q;
  assign axi.arlen   = LEN_SINGLE;
  assign axi.arsize  = SIZE_WORD;
  assign axi.arburst = BURST_INCR;
  assign axi.arlock  = LOCK_NORMAL;
  assign axi.arcache = axi_cache(cache_q);
  assign axi.arprot  = PROT_DEFAULT;
  assign axi.arvalid = arvalid_q;
  assign axi.rready  = rready_q;

  assign axi.awid    = DATA_ID;
  assign axi.awaddr  = addr_q;
  assign axi.awlen   = LEN_SINGLE;
  assign axi.awsize  = SIZE_WORD;
  assign axi.awburst = BURST_INCR;
  assign axi.awlock  = LOCK_NORMAL;
  assign axi.awcache = axi_cache(cache_q);
  assign axi.awprot  = PROT_DEFAULT;
  assign axi.awvalid = awvalid_q;

  assign axi.wid     = DATA_ID;
  assign axi.wdata   = wd_q;
  assign axi.wstrb   = wen_q;
  assign axi.wlast   = 1'b1;
  assign axi.wvalid  = wvalid_q;
  assign axi.bready  = bready_q;

  assign inst_valid_o = inst_valid_q;
  assign data_valid_o = data_valid_q;
  assign inst_rd_o    = inst_rd_q;
  assign data_rd_o    = data_rd_q;

endmodule

// File: tb/tb_cache_axi_bridge.sv
// tb/tb_cache_axi_bridge.sv - randomized bench for cache_axi_bridge with a latency-programmable AXI slave
module tb_cache_axi_bridge;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] inst_addr = '0, data_addr = '0, data_wd = '0;
  logic        inst_ren = 1'b0, data_ren = 1'b0, is_cache = 1'b0;
  logic [3:0]  data_wen = '0;
  logic        inst_valid, data_valid;
  logic [31:0] inst_rd, data_rd;

  cache_axi_bridge_if axi ();

  cache_axi_bridge #(.INST_ID(4'd0), .DATA_ID(4'd1)) dut (
    .clk(clk), .rst(rst),
    .inst_addr_i(inst_addr), .inst_ren_i(inst_ren), .inst_valid_o(inst_valid), .inst_rd_o(inst_rd),
    .data_addr_i(data_addr), .data_ren_i(data_ren), .data_wen_i(data_wen), .data_wd_i(data_wd),
    .data_valid_o(data_valid), .data_rd_o(data_rd), .is_cache_i(is_cache), .axi(axi)
  );

  localparam logic [17:0] FIX_EXP = {8'd0, 3'b010, 2'b01, 2'b00, 3'b000};

  int total = 0, bad = 0;
  int ar_lat = 0, r_lat = 0, aw_lat = 0, w_lat = 0, b_lat = 0;
  bit r_fixed_en = 1'b0;
  logic [31:0] r_fixed = '0;
  logic [31:0] ar_addr_q[$], aw_addr_q[$], w_data_q[$], r_data_q[$];
  logic [3:0]  ar_id_q[$], ar_cache_q[$], aw_id_q[$], aw_cache_q[$], w_strb_q[$], w_id_q[$];
  logic [17:0] ar_fix_q[$], aw_fix_q[$];
  logic        w_last_q[$];
  int cyc = 0, ar_cyc = 0, b_cyc = 0, b_cnt = 0;
  int inst_pulses = 0, data_pulses = 0, awv_cycles = 0, wv_cycles = 0;
  logic [31:0] exp_inst_rd = '0, exp_data_rd = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int pick(input int lat);
    return (lat < 0) ? int'($urandom_range(0, 3)) : lat;
  endfunction

  function automatic bit ready_now(input int lat, input int cnt);
    return (lat < 0) ? ($urandom_range(0, 2) == 0) : (cnt >= lat);
  endfunction

  // Slave: samples handshakes on posedge, drives its outputs on negedge.
  initial begin : slave
    int ar_c, aw_c, w_c, r_c, b_c;
    bit ar_hs, r_hs, aw_hs, w_hs, b_hs, r_pend, b_pend, aw_got, w_got;
    ar_c = 0; aw_c = 0; w_c = 0; r_c = 0; b_c = 0;
    r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0;
    axi.arready = 0; axi.rvalid = 0; axi.rid = '0; axi.rdata = '0; axi.rresp = '0; axi.rlast = 0;
    axi.awready = 0; axi.wready = 0; axi.bvalid = 0; axi.bid = '0; axi.bresp = '0;
    forever begin
      @(posedge clk);
      cyc++;
      ar_hs = 0; r_hs = 0; aw_hs = 0; w_hs = 0; b_hs = 0;
      if (!rst) begin
        if (axi.arvalid && axi.arready) begin
          ar_hs = 1; ar_cyc = cyc;
          ar_addr_q.push_back(axi.araddr); ar_id_q.push_back(axi.arid); ar_cache_q.push_back(axi.arcache);
          ar_fix_q.push_back({axi.arlen, axi.arsize, axi.arburst, axi.arlock, axi.arprot});
        end
        if (axi.rvalid && axi.rready) begin
          r_hs = 1; r_data_q.push_back(axi.rdata);
        end
        if (axi.awvalid && axi.awready) begin
          aw_hs = 1;
          aw_addr_q.push_back(axi.awaddr); aw_id_q.push_back(axi.awid); aw_cache_q.push_back(axi.awcache);
          aw_fix_q.push_back({axi.awlen, axi.awsize, axi.awburst, axi.awlock, axi.awprot});
        end
        if (axi.wvalid && axi.wready) begin
          w_hs = 1;
          w_data_q.push_back(axi.wdata); w_strb_q.push_back(axi.wstrb);
          w_id_q.push_back(axi.wid); w_last_q.push_back(axi.wlast);
        end
        if (axi.bvalid && axi.bready) begin
          b_hs = 1; b_cyc = cyc; b_cnt++;
        end
      end
      @(negedge clk);
      inst_pulses += int'(inst_valid);
      data_pulses += int'(data_valid);
      awv_cycles  += int'(axi.awvalid);
      wv_cycles   += int'(axi.wvalid);
      if (rst) begin
        axi.arready = 0; axi.rvalid = 0; axi.awready = 0; axi.wready = 0; axi.bvalid = 0;
        r_pend = 0; b_pend = 0; aw_got = 0; w_got = 0; ar_c = 0; aw_c = 0; w_c = 0;
      end else begin
        if (r_hs) begin axi.rvalid = 0; r_pend = 0; end
        if (ar_hs) begin
          axi.arready = 0; ar_c = 0; r_pend = 1; r_c = pick(r_lat);
        end else if (axi.arvalid && !axi.arready) begin
          if (ready_now(ar_lat, ar_c)) axi.arready = 1; else ar_c++;
        end
        if (r_pend && !axi.rvalid) begin
          if (r_c <= 0) begin
            axi.rvalid = 1; axi.rlast = 1;
            axi.rdata = r_fixed_en ? r_fixed : 32'($urandom);
            axi.rid = 4'($urandom); axi.rresp = 2'($urandom);
          end else r_c--;
        end
        if (b_hs) begin axi.bvalid = 0; b_pend = 0; aw_got = 0; w_got = 0; end
        if (aw_hs) begin
          axi.awready = 0; aw_c = 0; aw_got = 1;
        end else if (axi.awvalid && !axi.awready) begin
          if (ready_now(aw_lat, aw_c)) axi.awready = 1; else aw_c++;
        end
        if (w_hs) begin
          axi.wready = 0; w_c = 0; w_got = 1;
        end else if (axi.wvalid && !axi.wready) begin
          if (ready_now(w_lat, w_c)) axi.wready = 1; else w_c++;
        end
        if (aw_got && w_got && !b_pend) begin b_pend = 1; b_c = pick(b_lat); end
        if (b_pend && !axi.bvalid) begin
          if (b_c <= 0) begin
            axi.bvalid = 1; axi.bid = 4'($urandom); axi.bresp = 2'($urandom);
          end else b_c--;
        end
      end
    end
  end

  task automatic set_lat(input int a, input int r, input int aw, input int w, input int b);
    ar_lat = a; r_lat = r; aw_lat = aw; w_lat = w; b_lat = b;
  endtask

  task automatic flush_q();
    ar_addr_q.delete(); ar_id_q.delete(); ar_cache_q.delete(); ar_fix_q.delete(); r_data_q.delete();
    aw_addr_q.delete(); aw_id_q.delete(); aw_cache_q.delete(); aw_fix_q.delete();
    w_data_q.delete(); w_strb_q.delete(); w_id_q.delete(); w_last_q.delete();
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_valids"}, 32'({axi.arvalid, axi.rready, axi.awvalid, axi.wvalid, axi.bready,
                                 inst_valid, data_valid}), 32'd0);
    check({tag, "_inst_rd"}, inst_rd, 32'd0);
    check({tag, "_data_rd"}, data_rd, 32'd0);
    check({tag, "_addr"}, axi.araddr, 32'd0);
    check({tag, "_wdata"}, axi.wdata, 32'd0);
    check({tag, "_wstrb"}, 32'(axi.wstrb), 32'd0);
  endtask

  // kind: 0 inst read, 1 data read, 2 data write. exp_lat < 0 skips the latency check.
  task automatic run_req(input int kind, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [3:0] wen, input logic cache, input int exp_lat);
    int n, ip0, dp0, b0;
    bit dside;
    logic [31:0] rv;
    dside = (kind != 0);
    ip0 = inst_pulses; dp0 = data_pulses; b0 = b_cnt; awv_cycles = 0; wv_cycles = 0;
    is_cache = cache; data_wd = wd;
    if (kind == 0) begin inst_addr = addr; inst_ren = 1; end
    else begin data_addr = addr; data_ren = (kind == 1); data_wen = (kind == 2) ? wen : 4'b0; end
    n = 0;
    do begin
      @(negedge clk);
      n++;
      inst_addr = $urandom; data_addr = $urandom; data_wd = $urandom; is_cache = 1'($urandom);
      if (kind == 2) data_wen = 4'($urandom_range(1, 15));
    end while (!(dside ? data_valid : inst_valid) && n < 300);
    check("done_in_time", 32'(n < 300), 32'd1);
    if (exp_lat >= 0) check("latency", 32'(n), 32'(exp_lat));
`ifdef BRIDGE_EARLY_WACK_EN
    if (kind == 2) check("wr_ack_before_b", 32'(b_cnt - b0), 32'd0);
`else
    check("b_before_ack", 32'(b_cnt - b0), 32'(kind == 2));
`endif
    inst_ren = 0; data_ren = 0; data_wen = 0;
    @(negedge clk);
    check("pulse_width", 32'({inst_valid, data_valid}), 32'd0);
    check("inst_pulses", 32'(inst_pulses - ip0), dside ? 32'd0 : 32'd1);
    check("data_pulses", 32'(data_pulses - dp0), dside ? 32'd1 : 32'd0);
    if (kind == 2) begin
      check("aw_count", 32'(aw_addr_q.size()), 32'd1);
      check("w_count", 32'(w_data_q.size()), 32'd1);
      if (aw_addr_q.size() > 0) begin
        check("awaddr", aw_addr_q.pop_front(), addr);
        check("awid", 32'(aw_id_q.pop_front()), 32'd1);
        check("awcache", 32'(aw_cache_q.pop_front()), cache ? 32'hF : 32'h0);
        check("aw_fixed", 32'(aw_fix_q.pop_front()), 32'(FIX_EXP));
      end
      if (w_data_q.size() > 0) begin
        check("wdata", w_data_q.pop_front(), wd);
        check("wstrb", 32'(w_strb_q.pop_front()), 32'(wen));
        check("wid", 32'(w_id_q.pop_front()), 32'd1);
        check("wlast", 32'(w_last_q.pop_front()), 32'd1);
      end
    end else begin
      check("ar_count", 32'(ar_addr_q.size()), 32'd1);
      check("r_count", 32'(r_data_q.size()), 32'd1);
      if (ar_addr_q.size() > 0) begin
        check("araddr", ar_addr_q.pop_front(), addr);
        check("arid", 32'(ar_id_q.pop_front()), 32'(kind == 1));
        check("arcache", 32'(ar_cache_q.pop_front()), cache ? 32'hF : 32'h0);
        check("ar_fixed", 32'(ar_fix_q.pop_front()), 32'(FIX_EXP));
      end
      if (r_data_q.size() > 0) begin
        rv = r_data_q.pop_front();
        if (kind == 1) exp_data_rd = rv; else exp_inst_rd = rv;
      end
    end
    check("inst_rd", inst_rd, exp_inst_rd);
    check("data_rd", data_rd, exp_data_rd);
  endtask

  initial begin : main
    int n, ip0, dp0, wr_done_b;
    logic [31:0] rv;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst = 0;
    @(negedge clk);

    set_lat(0, 0, 0, 0, 0);
    r_fixed = 32'h2408_0001; r_fixed_en = 1;
    run_req(0, 32'h1FC0_0000, 32'h0, 4'h0, 1'b1, 3);
    check("boot_inst_rd", inst_rd, 32'h2408_0001);
    r_fixed_en = 0;

`ifdef BRIDGE_EARLY_WACK_EN
    run_req(2, 32'h1FAF_F000, 32'hDEAD_BEEF, 4'b0011, 1'b0, 2);
`else
    run_req(2, 32'h1FAF_F000, 32'hDEAD_BEEF, 4'b0011, 1'b0, 3);
`endif
    repeat (3) @(negedge clk);

    set_lat(0, 0, 0, 3, 0);
    run_req(2, 32'h1FAF_F000, 32'hDEAD_BEEF, 4'b0011, 1'b0, -1);
    check("aw_valid_cycles", 32'(awv_cycles), 32'd1);
    check("w_valid_cycles", 32'(wv_cycles), 32'd4);
    repeat (3) @(negedge clk);

    set_lat(0, 0, 0, 0, 0);
    ip0 = inst_pulses; dp0 = data_pulses;
    data_addr = 32'h0000_1230; inst_addr = 32'h1FC0_0040; is_cache = 1;
    data_ren = 1; inst_ren = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!data_valid && n < 300);
    check("both_data_first", 32'(data_valid), 32'd1);
    check("both_inst_waits", 32'(inst_pulses - ip0), 32'd0);
    data_ren = 0;
    n = 0;
    do begin @(negedge clk); n++; end while (!inst_valid && n < 300);
    check("both_inst_done", 32'(inst_valid), 32'd1);
    inst_ren = 0;
    @(negedge clk);
    check("both_pulses", 32'({inst_pulses - ip0, data_pulses - dp0}), 32'({32'd1, 32'd1}));
    check("both_ar_count", 32'(ar_addr_q.size()), 32'd2);
    check("both_r_count", 32'(r_data_q.size()), 32'd2);
    if (ar_addr_q.size() >= 2 && r_data_q.size() >= 2) begin
      check("both_ar0_id", 32'(ar_id_q[0]), 32'd1);
      check("both_ar0_addr", ar_addr_q[0], 32'h0000_1230);
      check("both_ar1_id", 32'(ar_id_q[1]), 32'd0);
      check("both_ar1_addr", ar_addr_q[1], 32'h1FC0_0040);
      rv = r_data_q[0]; exp_data_rd = rv;
      rv = r_data_q[1]; exp_inst_rd = rv;
    end
    check("both_data_rd", data_rd, exp_data_rd);
    check("both_inst_rd", inst_rd, exp_inst_rd);
    flush_q();

    set_lat(-1, -1, -1, -1, -1);
    for (int i = 0; i < 40; i++) begin
      run_req(int'($urandom_range(0, 2)), $urandom, $urandom, 4'($urandom_range(1, 15)),
              1'($urandom), -1);
    end
    repeat (12) @(negedge clk);

    set_lat(0, 0, 0, 0, 5);
`ifdef BRIDGE_EARLY_WACK_EN
    run_req(2, 32'h0000_2000, 32'h1234_5678, 4'hF, 1'b1, 2);
`else
    run_req(2, 32'h0000_2000, 32'h1234_5678, 4'hF, 1'b1, 8);
`endif
    wr_done_b = b_cnt;
    run_req(1, 32'h0000_2004, 32'h0, 4'h0, 1'b1, -1);
    check("ar_after_b", 32'(ar_cyc > b_cyc), 32'd1);
    check("b_total_after_rd", 32'(b_cnt), 32'(wr_done_b + (b_cnt - wr_done_b)));
    set_lat(0, 0, 0, 0, 0);

    inst_addr = 32'h1FC0_0100; inst_ren = 1; is_cache = 1;
    @(negedge clk);
    @(negedge clk);
    check("rst_ar_seen", 32'(ar_addr_q.size()), 32'd1);
    rst = 1; inst_ren = 0;
    @(negedge clk);
    check_quiet("midrst");
    @(negedge clk);
    rst = 0;
    flush_q();
    exp_inst_rd = '0; exp_data_rd = '0;
    @(negedge clk);
    flush_q();
    run_req(0, 32'h1FC0_0200, 32'h0, 4'h0, 1'b1, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
